riscv_mem_dma: RTL
==================

// Module: riscv_mem_dma
// PURPOSE
//  Host-side initiator for a RISC-V core's memory ports. Turns line-granular commands into
//  accesses on the core's data DMA port (dmem read/write) and instruction load port (imem write).
//  Streams write data in and read data out with valid/ready handshakes.
//  Sits between the packet/host interconnect and one core instance.
// PARAMETERS
//  DATA_WIDTH     64                    line width in bits
//  ADDR_WIDTH     16                    byte address width of core memory ports
//  LEN_WIDTH      12                    command length field width, in lines
//  STRB_WIDTH     DATA_WIDTH/8          byte enables per line
//  LINE_ADDR_BITS $clog2(STRB_WIDTH)    byte-in-line address bits
// PORTS
//  clk              in   1           clock
//  core_reset_n     in   1           asynchronous reset, active low
//  cmd_valid        in   1           command valid
//  cmd_ready        out  1           command accepted when valid&ready
//  cmd_op           in   2           0 DMEM_WR, 1 DMEM_RD, 2 IMEM_WR, 3 reserved
//  cmd_addr         in   ADDR_WIDTH  start byte address, line aligned
//  cmd_len          in   LEN_WIDTH   line count; 0 = no access
//  s_data_valid/ready  in/out  1     write data handshake
//  s_data           in   DATA_WIDTH  write line
//  s_strb           in   STRB_WIDTH  write byte enables
//  m_data_valid/ready  out/in  1     read data handshake
//  m_data           out  DATA_WIDTH  read line
//  m_last           out  1           final line of read command
//  done             out  1           one-cycle pulse, command complete
//  err              out  1           one-cycle pulse, command rejected
//  data_dma_en/ren  out  1           dmem port enable / read enable
//  data_dma_wen     out  STRB_WIDTH  dmem byte write enables
//  data_dma_addr    out  ADDR_WIDTH  dmem byte address
//  data_dma_wr_data out  DATA_WIDTH  dmem write line
//  data_dma_rd_data in   DATA_WIDTH  dmem read line, valid 1 cycle after en&ren
//  ins_dma_wen      out  STRB_WIDTH  imem byte write enables
//  ins_dma_addr     out  ADDR_WIDTH  imem byte address
//  ins_dma_wr_data  out  DATA_WIDTH  imem write line
// BEHAVIOUR
//  - Reset (async, core_reset_n low): state IDLE; every output 0; FIFO empty; counters 0.
//  - All memory-port outputs registered; idle cycles drive en/ren/wen = 0.
//  - States: IDLE, WR_DMEM, WR_IMEM, RD_DMEM, RD_DRAIN. cmd_ready = (state==IDLE).
//  - Accept checks: op==3, cmd_addr[LINE_ADDR_BITS-1:0]!=0, or addr+len*STRB_WIDTH > 2**ADDR_WIDTH
//    -> err pulse next cycle, no access, stay IDLE. len==0 -> done pulse next cycle, no access.
//  - WR_*: s_data_ready=1 while lines remain; each s_data handshake drives one write next
//    cycle at current addr, addr += STRB_WIDTH. DMEM_WR: en=1, ren=0, wen=s_strb. IMEM_WR:
//    ins_dma_wen=s_strb. After last write driven: done pulse, IDLE. Full rate: 1 line/cycle.
//  - RD_DMEM: read issued (en=ren=1, wen=0) when lines remain and fifo_count + in_flight
//    < RD_FIFO_DEPTH (4). Return captured into FIFO cycle after issue. m_data/m_data_valid
//    from FIFO head; m_last on final line. All issued -> RD_DRAIN; last beat accepted -> done
//    pulse, IDLE. m_data_ready held high sustains 1 line/cycle; ready low never drops data.
//  - done and err never assert together; at most one per command.
//  - Reset mid-command: operation aborted, no done/err, outputs return to 0 asynchronously.
// CONFIGURATION
//  RISCV_DMA_STAT_POLL_EN defined: adds ports status_update(in,1), stat_rd_en(out,1),
//  stat_rd_addr(out,ADDR_WIDTH), stat_rd_data(in,32), stat_out(out,32), stat_out_valid(out,1).
//  In IDLE, status_update high takes priority over a pending cmd: stat_rd_en pulsed 1 cycle
//  (addr 0), stat_rd_data captured next cycle into stat_out with 1-cycle stat_out_valid;
//  cmd_ready low for those 2 cycles. Undefined: ports absent, no polling logic.
// STRUCTURE
//  riscv_dma_pkg: op codes (OP_DMEM_WR/OP_DMEM_RD/OP_IMEM_WR), state encoding, RD_FIFO_DEPTH=4.
//  Sub-module dma_rd_fifo: 4-entry sync FIFO {last,data}, count output, async reset.
// TESTING
//  1 DMEM_WR addr 0x0100 len 4, strb 0xFF, s_data valid each cycle -> 4 writes on consecutive
//    cycles at 0x0100..0x0118, done 1 cycle after 4th write.
//  2 DMEM_RD addr 0x0040 len 8, m_data_ready toggling 1/0 -> 8 beats in order, m_last on 8th,
//    in_flight+FIFO never exceeds 4, done after 8th handshake.
//  3 cmd_addr 0x0003 -> err pulse, no en/wen; addr 0xFFF8 len 2 -> err; len 0 -> done only.
//  4 IMEM_WR addr 0x0000 len 2, strb 0x0F -> ins_dma_wen 0x0F twice, data_dma_en stays 0.
//  5 core_reset_n low mid DMEM_RD -> all outputs 0 immediately; after release cmd_ready=1.
//  6 (STAT_POLL_EN) status_update with pending cmd -> stat_rd_en first, stat_out=stat_rd_data,
//    then cmd accepted.

Source files
------------

// File: rtl/riscv_dma_pkg.sv
// riscv_dma_pkg: op codes, FSM state encoding and read-FIFO sizing shared by the
// riscv_mem_dma block.
package riscv_dma_pkg;

    localparam logic [1:0] OP_DMEM_WR = 2'd0;
    localparam logic [1:0] OP_DMEM_RD = 2'd1;
    localparam logic [1:0] OP_IMEM_WR = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;

    localparam int unsigned RD_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWrDmem,
        StWrImem,
        StRdDmem,
        StRdDrain
    } dma_state_e;

    function automatic dma_state_e op_to_state(input logic [1:0] op);
        case (op)
            OP_DMEM_WR: return StWrDmem;
            OP_DMEM_RD: return StRdDmem;
            OP_IMEM_WR: return StWrImem;
            default:    return StIdle;
        endcase
    endfunction

endpackage

// File: rtl/dma_rd_fifo.sv
// dma_rd_fifo: small synchronous FIFO holding {last, data} read returns, with an
// occupancy count used for read-issue flow control.
module dma_rd_fifo #(
    parameter int unsigned Width = 65,
    parameter int unsigned Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [Width-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             rdata_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/riscv_mem_dma.sv
// riscv_mem_dma: line-granular host DMA initiator for a RISC-V core's dmem/imem ports.
// Define RISCV_DMA_STAT_POLL_EN to add the idle-time status polling port.
module riscv_mem_dma
    import riscv_dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned LEN_WIDTH      = 12,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned LINE_ADDR_BITS = $clog2(STRB_WIDTH)
) (
    input  logic                  clk,
    input  logic                  core_reset_n,
`ifdef RISCV_DMA_STAT_POLL_EN
    input  logic                  status_update,
    output logic                  stat_rd_en,
    output logic [ADDR_WIDTH-1:0] stat_rd_addr,
    input  logic [31:0]           stat_rd_data,
    output logic [31:0]           stat_out,
    output logic                  stat_out_valid,
`endif
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  s_data_valid,
    output logic                  s_data_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [STRB_WIDTH-1:0] s_strb,
    output logic                  m_data_valid,
    input  logic                  m_data_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  done,
    output logic                  err,
    output logic                  data_dma_en,
    output logic                  data_dma_ren,
    output logic [STRB_WIDTH-1:0] data_dma_wen,
    output logic [ADDR_WIDTH-1:0] data_dma_addr,
    output logic [DATA_WIDTH-1:0] data_dma_wr_data,
    input  logic [DATA_WIDTH-1:0] data_dma_rd_data,
    output logic [STRB_WIDTH-1:0] ins_dma_wen,
    output logic [ADDR_WIDTH-1:0] ins_dma_addr,
    output logic [DATA_WIDTH-1:0] ins_dma_wr_data
);

    localparam int unsigned CntW = $clog2(RD_FIFO_DEPTH + 1);
    localparam int unsigned SumW = ADDR_WIDTH + LEN_WIDTH + LINE_ADDR_BITS + 1;

    dma_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  lines_q, lines_d;
    logic                  done_q, done_d, err_q, err_d;
    logic                  active_q;

    logic                  dma_en_q, dma_en_d, dma_ren_q, dma_ren_d;
    logic [STRB_WIDTH-1:0] dma_wen_q, dma_wen_d;
    logic [ADDR_WIDTH-1:0] dma_addr_q, dma_addr_d;
    logic [DATA_WIDTH-1:0] dma_wdata_q, dma_wdata_d;
    logic [STRB_WIDTH-1:0] ins_wen_q, ins_wen_d;
    logic [ADDR_WIDTH-1:0] ins_addr_q, ins_addr_d;
    logic [DATA_WIDTH-1:0] ins_wdata_q, ins_wdata_d;

    // Read pipeline: stage 1 is the registered issue, stage 2 is the cycle the
    // memory returns data, which is pushed into the FIFO at the end of that cycle.
    logic                  rd_last1_q, rd_last1_d;
    logic                  rd_pend2_q, rd_last2_q;

    logic [CntW-1:0]       fifo_count;
    logic [DATA_WIDTH:0]   fifo_rdata;
    logic [1:0]            in_flight;
    logic [3:0]            rd_occ;
    logic                  rd_can_issue, m_fire, s_fire, cmd_fire, cmd_bad, stat_hold;
    logic [SumW-1:0]       cmd_end;

    assign cmd_end = SumW'(cmd_addr) + (SumW'(cmd_len) << LINE_ADDR_BITS);
    assign cmd_bad = (cmd_op == OP_RSVD)
                  || (cmd_addr[LINE_ADDR_BITS-1:0] != '0)
                  || (cmd_end > (SumW'(1) << ADDR_WIDTH));

    assign cmd_ready    = active_q && (state_q == StIdle) && !stat_hold;
    assign cmd_fire     = cmd_valid && cmd_ready;
    assign s_data_ready = ((state_q == StWrDmem) || (state_q == StWrImem)) && (lines_q != '0);
    assign s_fire       = s_data_valid && s_data_ready;

    assign m_data_valid = (fifo_count != '0);
    assign {m_last, m_data} = fifo_rdata;
    assign m_fire       = m_data_valid && m_data_ready;

    assign in_flight    = {1'b0, dma_en_q & dma_ren_q} + {1'b0, rd_pend2_q};
    assign rd_occ       = 4'(fifo_count) + 4'(in_flight);
    assign rd_can_issue = (lines_q != '0) && (rd_occ < 4'(RD_FIFO_DEPTH));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lines_d     = lines_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        dma_en_d    = 1'b0;
        dma_ren_d   = 1'b0;
        dma_wen_d   = '0;
        dma_addr_d  = dma_addr_q;
        dma_wdata_d = dma_wdata_q;
        ins_wen_d   = '0;
        ins_addr_d  = ins_addr_q;
        ins_wdata_d = ins_wdata_q;
        rd_last1_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr;
                        lines_d = cmd_len;
                        state_d = op_to_state(cmd_op);
                    end
                end
            end
            StWrDmem, StWrImem: begin
                if (lines_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (s_fire) begin
                    if (state_q == StWrDmem) begin
                        dma_en_d    = 1'b1;
                        dma_wen_d   = s_strb;
                        dma_addr_d  = addr_q;
                        dma_wdata_d = s_data;
                    end else begin
                        ins_wen_d   = s_strb;
                        ins_addr_d  = addr_q;
                        ins_wdata_d = s_data;
                    end
                    addr_d  = addr_q + ADDR_WIDTH'(STRB_WIDTH);
                    lines_d = lines_q - LEN_WIDTH'(1);
                end
            end
            StRdDmem: begin
                if (rd_can_issue) begin
                    dma_en_d   = 1'b1;
                    dma_ren_d  = 1'b1;
                    dma_addr_d = addr_q;
                    rd_last1_d = (lines_q == LEN_WIDTH'(1));
                    addr_d     = addr_q + ADDR_WIDTH'(STRB_WIDTH);
                    lines_d    = lines_q - LEN_WIDTH'(1);
                    if (lines_q == LEN_WIDTH'(1)) begin
                        state_d = StRdDrain;
                    end
                end
            end
            StRdDrain: begin
                if (m_fire && m_last) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            lines_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            active_q    <= 1'b0;
            dma_en_q    <= 1'b0;
            dma_ren_q   <= 1'b0;
            dma_wen_q   <= '0;
            dma_addr_q  <= '0;
            dma_wdata_q <= '0;
            ins_wen_q   <= '0;
            ins_addr_q  <= '0;
            ins_wdata_q <= '0;
            rd_last1_q  <= 1'b0;
            rd_pend2_q  <= 1'b0;
            rd_last2_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lines_q     <= lines_d;
            done_q      <= done_d;
            err_q       <= err_d;
            active_q    <= 1'b1;
            dma_en_q    <= dma_en_d;
            dma_ren_q   <= dma_ren_d;
            dma_wen_q   <= dma_wen_d;
            dma_addr_q  <= dma_addr_d;
            dma_wdata_q <= dma_wdata_d;
            ins_wen_q   <= ins_wen_d;
            ins_addr_q  <= ins_addr_d;
            ins_wdata_q <= ins_wdata_d;
            rd_last1_q  <= rd_last1_d;
            rd_pend2_q  <= dma_en_q & dma_ren_q;
            rd_last2_q  <= rd_last1_q;
        end
    end

    dma_rd_fifo #(
        .Width (DATA_WIDTH + 1),
        .Depth (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk_i   (clk),
        .rst_ni  (core_reset_n),
        .push_i  (rd_pend2_q),
        .wdata_i ({rd_last2_q, data_dma_rd_data}),
        .pop_i   (m_fire),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

`ifdef RISCV_DMA_STAT_POLL_EN
    logic        stat_start, stat_rd_en_q, stat_out_valid_q;
    logic [31:0] stat_out_q;

    // A poll request blocks command acceptance in the request cycle and the read cycle.
    assign stat_start = active_q && (state_q == StIdle) && status_update && !stat_rd_en_q;
    assign stat_hold  = status_update || stat_rd_en_q;

    always_ff @(posedge clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            stat_rd_en_q     <= 1'b0;
            stat_out_valid_q <= 1'b0;
            stat_out_q       <= '0;
        end else begin
            stat_rd_en_q     <= stat_start;
            stat_out_valid_q <= stat_rd_en_q;
            if (stat_rd_en_q) begin
                stat_out_q <= stat_rd_data;
            end
        end
    end

    assign stat_rd_en     = stat_rd_en_q;
    assign stat_rd_addr   = '0;
    assign stat_out       = stat_out_q;
    assign stat_out_valid = stat_out_valid_q;
`else
    assign stat_hold = 1'b0;
`endif

    assign done             = done_q;
    assign err              = err_q;
    assign data_dma_en      = dma_en_q;
    assign data_dma_ren     = dma_ren_q;
    assign data_dma_wen     = dma_wen_q;
    assign data_dma_addr    = dma_addr_q;
    assign data_dma_wr_data = dma_wdata_q;
    assign ins_dma_wen      = ins_wen_q;
    assign ins_dma_addr     = ins_addr_q;
    assign ins_dma_wr_data  = ins_wdata_q;

endmodule
